// File: rtl/mem_arb_pkg.sv
// Shared types, default sizes and the address legality rule for the
// unified-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    I_RD  = 3'd1,
    D_RD  = 3'd2,
    D_WR  = 3'd3,
    I_ERR = 3'd4,
    D_ERR = 3'd5
  } resp_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Word aligned and inside the 2^aw-word RAM window.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker. Bit 0 is the fetch port, bit 1 the
// data port; a tie goes to whichever port was not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_e last_gnt;

  // Grant is held low for the whole time reset is asserted.
  always_comb begin
    gnt = 2'b00;
    if (reset_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt == PORT_D) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= PORT_D;
    end else if (advance) begin
      last_gnt <= gnt[1] ? PORT_D : PORT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (I) and
// load/store (D) ports, routing one-cycle read data back to its requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        state
);

  // Handshake: a port holds req/addr/we/wdata stable until gnt is high at a
  // rising edge; gnt is combinational and one grant at most is made per cycle.

  logic [1:0]        gnt;
  logic              i_ok, d_ok;
  logic [ADDR_W-1:0] i_word, d_word;
  resp_state_e       st, nxt;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({d_req, i_req}),
    .advance (|gnt),
    .gnt     (gnt)
  );

  assign i_gnt  = gnt[0];
  assign d_gnt  = gnt[1];
  assign i_ok   = addr_ok(i_addr, ADDR_W);
  assign d_ok   = addr_ok(d_addr, ADDR_W);
  assign i_word = i_addr[ADDR_W+1:2];
  assign d_word = d_addr[ADDR_W+1:2];

  // An illegal request is still granted but never reaches the RAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    nxt       = IDLE;
    if (i_gnt) begin
      if (i_ok) begin
        mem_en   = 1'b1;
        mem_addr = i_word;
        nxt      = I_RD;
      end else begin
        nxt = I_ERR;
      end
    end else if (d_gnt) begin
      if (d_ok) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_word;
        mem_wdata = d_wdata;
        nxt       = d_we ? D_WR : D_RD;
      end else begin
        nxt = D_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= IDLE;
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
    end else begin
      st       <= nxt;
      i_rvalid <= (nxt == I_RD) || (nxt == I_ERR);
      i_err    <= (nxt == I_ERR);
      d_rvalid <= (nxt == D_RD) || (nxt == D_ERR);
      d_err    <= (nxt == D_ERR);
    end
  end

  // Read data is steered only during a real read response; zero otherwise.
  assign i_rdata = (i_rvalid && !i_err) ? mem_rdata : '0;
  assign d_rdata = (d_rvalid && !d_err) ? mem_rdata : '0;
  assign state   = st;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, directed scenarios plus random traffic,
// reference model of arbitration/memory and a response scoreboard.
module tb_mem_arbiter;

  localparam int AW        = 6;
  localparam int DW        = 32;
  localparam int RAM_WORDS = 64;

  logic          clk, reset_n;
  logic          i_req, i_gnt, i_rvalid, i_err;
  logic [31:0]   i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0]    dut_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state(dut_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM environment ----------------
  logic [DW-1:0] ram [RAM_WORDS];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [RAM_WORDS];
  bit            m_last_d;
  // entry: {due cycle[30:0], err, data[31:0]}
  logic [63:0]   i_exp_q[$];
  logic [63:0]   d_exp_q[$];

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(RAM_WORDS * 4));
  endfunction

  function automatic logic [63:0] mk_exp(input bit err, input logic [31:0] data);
    return {31'(cyc + 1), err, data};
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
    if (r == 1) return 32'($urandom_range(1, 255)) << 8;
    return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  // ---------------- monitor ----------------
  task automatic mon(input bit p, input logic rv, input logic er, input logic [31:0] rd);
    logic [63:0] e;
    bit          have, hit;
    string       nm;
    nm   = p ? "d" : "i";
    hit  = 1'b0;
    have = p ? (d_exp_q.size() > 0) : (i_exp_q.size() > 0);
    if (have) begin
      e = p ? d_exp_q[0] : i_exp_q[0];
      if (e[63:33] < 31'(cyc)) begin
        check({nm, "_resp_late"}, 64'(cyc), 64'(e[63:33]));
        if (p) void'(d_exp_q.pop_front()); else void'(i_exp_q.pop_front());
      end else if (e[63:33] == 31'(cyc)) begin
        hit = 1'b1;
        check({nm, "_rvalid"}, 64'(rv), 64'd1);
        check({nm, "_err"}, 64'(er), 64'(e[32]));
        check({nm, "_rdata"}, 64'(rd), 64'(e[31:0]));
        if (p) void'(d_exp_q.pop_front()); else void'(i_exp_q.pop_front());
      end
    end
    if (!hit) begin
      check({nm, "_rvalid_idle"}, 64'(rv), 64'd0);
      check({nm, "_err_idle"}, 64'(er), 64'd0);
      check({nm, "_rdata_idle"}, 64'(rd), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0, i_rvalid, i_err, i_rdata);
    mon(1'b1, d_rvalid, d_err, d_rdata);
  end

  // ---------------- driver ----------------
  bit          i_pend, d_pend, d_w;
  logic [31:0] i_a, d_a, d_wd;
  int          i_wait, d_wait;

  task automatic issue_i(input logic [31:0] a);
    i_pend = 1'b1; i_a = a;
  endtask

  task automatic issue_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_pend = 1'b1; d_w = we; d_a = a; d_wd = wd;
  endtask

  task automatic drive_inputs();
    i_req   = i_pend;
    i_addr  = i_pend ? i_a : $urandom;
    d_req   = d_pend;
    d_we    = d_pend ? d_w : 1'($urandom_range(0, 1));
    d_addr  = d_pend ? d_a : $urandom;
    d_wdata = d_pend ? d_wd : $urandom;
  endtask

  // One clock cycle: drive, predict, compare, update the model.
  task automatic step();
    bit          pi, pd, e_en, e_we;
    logic [5:0]  e_addr;
    logic [31:0] e_wd;
    @(negedge clk);
    drive_inputs();
    #1;
    pi     = i_pend && (!d_pend || m_last_d);
    pd     = d_pend && !pi;
    e_en   = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    check("i_gnt", 64'(i_gnt), 64'(pi));
    check("d_gnt", 64'(d_gnt), 64'(pd));
    if (pi) begin
      if (legal(i_a)) begin
        e_en = 1'b1; e_addr = 6'(i_a / 4);
        i_exp_q.push_back(mk_exp(1'b0, ref_mem[e_addr]));
      end else begin
        i_exp_q.push_back(mk_exp(1'b1, 32'd0));
      end
    end else if (pd) begin
      if (legal(d_a)) begin
        e_en = 1'b1; e_we = d_w; e_addr = 6'(d_a / 4); e_wd = d_wd;
        if (d_w) ref_mem[e_addr] = d_wd;
        else     d_exp_q.push_back(mk_exp(1'b0, ref_mem[e_addr]));
      end else begin
        d_exp_q.push_back(mk_exp(1'b1, 32'd0));
      end
    end
    check("mem_en", 64'(mem_en), 64'(e_en));
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    if (!e_en || e_we) check("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    if (pi || pd) m_last_d = pd;
    i_wait = (i_pend && !pi) ? i_wait + 1 : 0;
    d_wait = (d_pend && !pd) ? d_wait + 1 : 0;
    if (i_pend) check("i_wait_bound", 64'(i_wait > 1), 64'd0);
    if (d_pend) check("d_wait_bound", 64'(d_wait > 1), 64'd0);
    if (i_gnt) i_pend = 1'b0;
    if (d_gnt) d_pend = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && (i_pend || d_pend); k++) step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; d_w = 1'b0;
    i_a = '0; d_a = '0; d_wd = '0; i_wait = 0; d_wait = 0;
    m_last_d = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < RAM_WORDS; k++) begin
      ram[k] = $urandom;
      ref_mem[k] = ram[k];
    end
    ram[2] = 32'h2002_0005; ref_mem[2] = 32'h2002_0005;
    ram[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;

    // Reset: requests present, grants must stay low.
    repeat (3) @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_addr = 32'h10;
    #1;
    check("rst_i_gnt", 64'(i_gnt), 64'd0);
    check("rst_d_gnt", 64'(d_gnt), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset.
    repeat (5) step();

    // Single fetch of RAM[2].
    issue_i(32'h08);
    step(); step();

    // Continuous contention: I fetch vs D load of RAM[4].
    for (int k = 0; k < 6; k++) begin
      if (!i_pend) issue_i(32'h08);
      if (!d_pend) issue_d(1'b0, 32'h10, 32'd0);
      step();
    end
    drain(); step();

    // Store then load the same word on the next cycle.
    issue_d(1'b1, 32'h3C, 32'hDEAD_BEEF);
    step();
    issue_d(1'b0, 32'h3C, 32'd0);
    step(); step();

    // Address errors on each port.
    issue_d(1'b0, 32'h0000_0102, 32'd0);
    step();
    issue_i(32'h0000_0100);
    step(); step();

    // Reset pulled during a granted load: the response must be dropped.
    issue_d(1'b0, 32'h10, 32'd0);
    @(negedge clk);
    drive_inputs();
    #1;
    check("rstmid_d_gnt", 64'(d_gnt), 64'd1);
    #2;
    reset_n = 1'b0;
    d_pend = 1'b0; i_pend = 1'b0; d_req = 1'b0; i_req = 1'b0;
    m_last_d = 1'b1; i_wait = 0; d_wait = 0;
    i_exp_q.delete(); d_exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
    issue_i(32'h08);
    step(); step();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      if (!i_pend && $urandom_range(0, 3) != 0) issue_i(rand_addr());
      if (!d_pend && $urandom_range(0, 3) != 0)
        issue_d(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      step();
    end
    drain();
    repeat (3) step();
    check("i_q_drained", 64'(i_exp_q.size()), 64'd0);
    check("d_q_drained", 64'(d_exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
